datamem_responder: RTL and testbench

DATAMEM_RESPONDER -- requirements
Module: datamem_responder

---
 rtl/datamem_responder_pkg.sv | 38 +++
 rtl/dmem_lane_align.sv | 59 +++++
 rtl/datamem_responder.sv | 134 +++++++++++++
 tb/tb_datamem_responder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/datamem_responder_pkg.sv
// datamem_responder_pkg
//   Shared definitions for the data-memory responder and the core-side
//   load/store unit: FSM state codes, funct3 size/sign encodings, the
//   latched request-op struct and small decode helpers.
package datamem_responder_pkg;

    // Responder FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // funct3 access encodings: [1:0] = log2(bytes), [2] = zero-extend
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic       wr;
        logic       rd;
        logic [2:0] funct3;
    } dmem_op_t;

    function automatic logic f3_legal(input logic [2:0] f3);
        return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

    // Natural alignment: halves on even bytes, words on 4-byte boundaries.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b01:   return lo[0];
            2'b10:   return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align
//   Combinational byte-lane steering for one memory word.
//   lane     : byte offset of the access inside the word
//   op       : wr/rd/funct3 of the access
//   wr_data  : right-aligned store data
//   rd_word  : current contents of the addressed word
//   be       : per-byte write enables (all zero on error or load)
//   wr_word  : store data shifted into its byte lanes
//   ld_data  : extracted and sign/zero-extended load data (zero unless a good load)
//   err      : illegal funct3, misalignment, or wr and rd together
module dmem_lane_align
    import datamem_responder_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int NB = DATA_W / 8,
    localparam int LB = $clog2(NB)
) (
    input  logic [LB-1:0]     lane,
    input  dmem_op_t          op,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rd_word,
    output logic [NB-1:0]     be,
    output logic [DATA_W-1:0] wr_word,
    output logic [DATA_W-1:0] ld_data,
    output logic              err
);

    logic [DATA_W-1:0] shifted;
    int                nbytes;

    always_comb begin
        err = (op.wr && op.rd) || !f3_legal(op.funct3) || f3_misaligned(op.funct3, lane[1:0]);

        case (op.funct3[1:0])
            2'b00:   nbytes = 1;
            2'b01:   nbytes = 2;
            default: nbytes = 4;
        endcase

        be = '0;
        for (int i = 0; i < NB; i++)
            be[i] = op.wr && !err && (i >= int'(lane)) && (i < int'(lane) + nbytes);

        wr_word = wr_data << (8 * int'(lane));
        shifted = rd_word >> (8 * int'(lane));

        ld_data = '0;
        if (op.rd && !err) begin
            case (nbytes)
                1:       ld_data = op.funct3[2] ? {{(DATA_W-8){1'b0}}, shifted[7:0]}
                                                : {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
                2:       ld_data = op.funct3[2] ? {{(DATA_W-16){1'b0}}, shifted[15:0]}
                                                : {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
                default: ld_data = shifted;
            endcase
        end
    end

endmodule

// File: rtl/datamem_responder.sv
// datamem_responder
//   Fixed-latency data memory. A request (wr or rd) is accepted in IDLE,
//   waits LATENCY cycles in WAIT, then responds for one cycle in RESP.
//   Stores commit and loads read on the edge entering RESP.
//   Ports:
//     clk, reset            : clock, async active-high reset
//     req_valid / req_ready : request handshake (ready only in IDLE)
//     wr, rd, addr, funct3  : access type, byte address, size/sign
//     wr_data               : right-aligned store data
//     rsp_valid             : one-cycle response strobe
//     rd_data, err          : load result / failure, zero outside RESP
//   DATA_W must be a multiple of 32 (word accesses are 4 bytes).
module datamem_responder
    import datamem_responder_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              wr,
    input  logic              rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              err
);

    localparam int NB    = DATA_W / 8;
    localparam int LB    = $clog2(NB);
    localparam int DEPTH = (1 << ADDR_W) / NB;
    localparam logic [3:0] LAT = 4'(LATENCY);

    logic [1:0]        state;
    logic [3:0]        cnt;
    dmem_op_t          op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              err_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              in_idle, accept, enter_resp;
    dmem_op_t          op_cur;
    logic [ADDR_W-1:0] addr_cur;
    logic [DATA_W-1:0] wr_data_cur;
    logic [DATA_W-1:0] rd_word, wr_word, ld_data;
    logic [NB-1:0]     be;
    logic              a_err;
    logic [ADDR_W-LB-1:0] word_idx;

    assign in_idle    = (state == ST_IDLE);
    assign req_ready  = in_idle;
    assign accept     = req_valid && in_idle && (wr || rd);
    assign enter_resp = (accept && LAT == 4'd0) || (state == ST_WAIT && cnt == 4'd1);

    // With zero latency the access happens on the accept edge itself, so the
    // live inputs are used; otherwise only the latched copy is ever looked at,
    // which keeps inputs that wiggle during WAIT from leaking in.
    assign op_cur      = in_idle ? dmem_op_t'({wr, rd, funct3}) : op_q;
    assign addr_cur    = in_idle ? addr    : addr_q;
    assign wr_data_cur = in_idle ? wr_data : wr_data_q;

    assign word_idx = addr_cur[ADDR_W-1:LB];
    assign rd_word  = mem[word_idx];

    dmem_lane_align #(.DATA_W(DATA_W)) u_align (
        .lane    (addr_cur[LB-1:0]),
        .op      (op_cur),
        .wr_data (wr_data_cur),
        .rd_word (rd_word),
        .be      (be),
        .wr_word (wr_word),
        .ld_data (ld_data),
        .err     (a_err)
    );

    // Storage is deliberately not reset. A store pending in WAIT never
    // commits across a reset because reset drops the FSM out of WAIT.
    always_ff @(posedge clk) begin
        if (enter_resp) begin
            for (int i = 0; i < NB; i++)
                if (be[i]) mem[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            op_q      <= '0;
            addr_q    <= '0;
            wr_data_q <= '0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    op_q      <= op_cur;
                    addr_q    <= addr;
                    wr_data_q <= wr_data;
                    cnt       <= LAT;
                    state     <= (LAT == 4'd0) ? ST_RESP : ST_WAIT;
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= ST_RESP;
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            // Response registers hold data only for the single RESP cycle.
            if (enter_resp) begin
                rd_data_q <= ld_data;
                err_q     <= a_err;
            end else begin
                rd_data_q <= '0;
                err_q     <= 1'b0;
            end
        end
    end

    assign rsp_valid = (state == ST_RESP);
    assign rd_data   = rd_data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_datamem_responder.sv
// tb_datamem_responder
//   Randomized bench for datamem_responder against a byte-array reference
//   model. Main instance uses LATENCY=2; a second instance uses LATENCY=0.
module tb_datamem_responder;
    import datamem_responder_pkg::*;

    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, wr, rd, req_ready, rsp_valid, err;
    logic [8:0]  addr;
    logic [2:0]  funct3;
    logic [31:0] wr_data, rd_data;

    logic        z_req_valid, z_wr, z_rd, z_req_ready, z_rsp_valid, z_err;
    logic [8:0]  z_addr;
    logic [2:0]  z_funct3;
    logic [31:0] z_wr_data, z_rd_data;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] mdl   [512];
    logic [7:0] z_mdl [512];

    datamem_responder #(.DATA_W(32), .ADDR_W(9), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .wr(wr), .rd(rd), .addr(addr), .funct3(funct3), .wr_data(wr_data),
        .rsp_valid(rsp_valid), .rd_data(rd_data), .err(err)
    );

    datamem_responder #(.DATA_W(32), .ADDR_W(9), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(z_req_valid), .req_ready(z_req_ready),
        .wr(z_wr), .rd(z_rd), .addr(z_addr), .funct3(z_funct3), .wr_data(z_wr_data),
        .rsp_valid(z_rsp_valid), .rd_data(z_rd_data), .err(z_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: little-endian byte array, sizes 1/2/4, sign rules from funct3.
    task automatic model(input bit z, input bit w, input bit r, input int a, input logic [2:0] f,
                         input logic [31:0] wd, output logic [31:0] exp_rd, output logic exp_err);
        int     sz;
        longint v;
        sz      = 1 << f[1:0];
        v       = 0;
        exp_rd  = '0;
        exp_err = (w && r) || f == 3'd3 || f == 3'd6 || f == 3'd7 ||
                  (sz == 2 && a % 2 != 0) || (sz == 4 && a % 4 != 0);
        if (exp_err) return;
        if (w) begin
            for (int k = 0; k < sz; k++)
                if (z) z_mdl[a+k] = wd[8*k +: 8];
                else   mdl[a+k]   = wd[8*k +: 8];
        end else begin
            for (int k = sz - 1; k >= 0; k--)
                v = v * 256 + longint'(z ? z_mdl[a+k] : mdl[a+k]);
            if (!f[2] && sz < 4 && v >= (longint'(1) << (8*sz - 1)))
                v = v - (longint'(1) << (8*sz));
            exp_rd = v[31:0];
        end
    endtask

    task automatic do_txn(input bit w, input bit r, input int a, input logic [2:0] f,
                          input logic [31:0] wd, output logic [31:0] got_rd, output logic got_err);
        logic [31:0] e_rd;
        logic        e_err;
        bit          seen;
        model(1'b0, w, r, a, f, wd, e_rd, e_err);
        @(negedge clk);
        chk("ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1; wr = w; rd = r; addr = a[8:0]; funct3 = f; wr_data = wd;
        @(posedge clk);
        seen = 1'b0; got_rd = '0; got_err = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen    = 1'b1;
                got_rd  = rd_data;
                got_err = err;
                chk("latency", 64'(k), 64'(LAT + 1));
                chk("rd_data", 64'(rd_data), 64'(e_rd));
                chk("err", 64'(err), 64'(e_err));
                req_valid = 1'b0;
            end else begin
                chk("ready_busy", 64'(req_ready), 64'd0);
                chk("quiet_out", 64'({err, rd_data}), 64'd0);
                // Garbage on the inputs while busy must be ignored.
                req_valid = 1'($urandom); wr = 1'($urandom); rd = 1'($urandom);
                addr = 9'($urandom); funct3 = 3'($urandom); wr_data = $urandom;
            end
        end
        if (!seen) chk("rsp_timeout", 64'd0, 64'd1);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rsp_one_cycle", 64'(rsp_valid), 64'd0);
    endtask

    task automatic do_txn0(input bit w, input int a, input logic [31:0] wd);
        logic [31:0] e_rd;
        logic        e_err;
        model(1'b1, w, !w, a, F3_W, wd, e_rd, e_err);
        @(negedge clk);
        chk("z_ready_idle", 64'(z_req_ready), 64'd1);
        z_req_valid = 1'b1; z_wr = w; z_rd = !w; z_addr = a[8:0]; z_funct3 = F3_W; z_wr_data = wd;
        @(negedge clk);
        chk("z_rsp", 64'(z_rsp_valid), 64'd1);
        chk("z_ready_low", 64'(z_req_ready), 64'd0);
        chk("z_rd_data", 64'(z_rd_data), 64'(e_rd));
        chk("z_err", 64'(z_err), 64'(e_err));
        z_req_valid = 1'b0;
        @(negedge clk);
        chk("z_ready_back", 64'(z_req_ready), 64'd1);
        chk("z_rsp_drop", 64'(z_rsp_valid), 64'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        int          a, kind;
        logic [2:0]  f;
        int          zaddr [8];

        reset = 1'b1;
        req_valid = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; funct3 = '0; wr_data = '0;
        z_req_valid = 1'b0; z_wr = 1'b0; z_rd = 1'b0; z_addr = '0; z_funct3 = '0; z_wr_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_rsp", 64'(rsp_valid), 64'd0);
        chk("rst_out", 64'({err, rd_data}), 64'd0);
        chk("rst_z_ready", 64'(z_req_ready), 64'd1);
        reset = 1'b0;

        // Give every word known contents.
        for (int i = 0; i < 128; i++) do_txn(1'b1, 1'b0, i * 4, F3_W, $urandom, r, e);

        // Request with neither wr nor rd is not accepted.
        @(negedge clk);
        req_valid = 1'b1; wr = 1'b0; rd = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("noop_ready", 64'(req_ready), 64'd1);
            chk("noop_rsp", 64'(rsp_valid), 64'd0);
        end
        req_valid = 1'b0;

        // Directed word/byte/half traffic
        do_txn(1'b1, 1'b0, 'h010, F3_W,  32'hDEADBEEF, r, e);
        chk("sw_rsp", 64'({e, r}), 64'd0);
        do_txn(1'b0, 1'b1, 'h010, F3_W,  '0, r, e);  chk("lw_010", 64'(r), 64'h0000_0000_DEAD_BEEF);
        do_txn(1'b0, 1'b1, 'h013, F3_B,  '0, r, e);  chk("lb_013", 64'(r), 64'h0000_0000_FFFF_FFDE);
        do_txn(1'b0, 1'b1, 'h013, F3_BU, '0, r, e);  chk("lbu_013", 64'(r), 64'h0000_0000_0000_00DE);
        do_txn(1'b0, 1'b1, 'h012, F3_H,  '0, r, e);  chk("lh_012", 64'(r), 64'h0000_0000_FFFF_DEAD);
        do_txn(1'b0, 1'b1, 'h010, F3_HU, '0, r, e);  chk("lhu_010", 64'(r), 64'h0000_0000_0000_BEEF);
        do_txn(1'b1, 1'b0, 'h011, F3_B,  32'h000000AA, r, e);
        do_txn(1'b0, 1'b1, 'h010, F3_W,  '0, r, e);  chk("sb_merge", 64'(r), 64'h0000_0000_DEAD_AAEF);
        do_txn(1'b0, 1'b1, 'h011, F3_W,  '0, r, e);  chk("lw_misal", 64'({e, r}), 64'h1_0000_0000);
        do_txn(1'b1, 1'b0, 'h013, F3_H,  32'h5555, r, e); chk("sh_misal", 64'({e, r}), 64'h1_0000_0000);
        do_txn(1'b1, 1'b1, 'h010, F3_W,  32'h1, r, e);   chk("wr_and_rd", 64'({e, r}), 64'h1_0000_0000);
        do_txn(1'b0, 1'b1, 'h010, 3'b011, '0, r, e);     chk("f3_illegal", 64'({e, r}), 64'h1_0000_0000);
        do_txn(1'b0, 1'b1, 'h010, F3_W,  '0, r, e);  chk("lw_unchanged", 64'(r), 64'h0000_0000_DEAD_AAEF);

        // Reset while a store sits in WAIT: discarded, memory untouched.
        @(negedge clk);
        req_valid = 1'b1; wr = 1'b1; rd = 1'b0; addr = 9'h020; funct3 = F3_W; wr_data = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_busy", 64'(req_ready), 64'd0);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(req_ready), 64'd1);
        chk("mid_rst_out", 64'({rsp_valid, err, rd_data}), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_hold", 64'(rsp_valid), 64'd0);
        reset = 1'b0;
        do_txn(1'b0, 1'b1, 'h020, F3_W, '0, r, e);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 9);
            f    = 3'($urandom);
            a    = $urandom_range(0, 511);
            if ($urandom_range(0, 3) != 0) a = a & ~((1 << f[1:0]) - 1) & 511;
            if (f == 3'd3 && $urandom_range(0, 3) != 0) f = F3_W;
            if (f == 3'd3) a = a & ~3;  // keep 8-byte-size decode from running off the model
            do_txn(kind == 0 || kind <= 3, kind == 0 || kind > 3, a, f, $urandom, r, e);
        end

        // Zero-latency instance
        for (int i = 0; i < 8; i++) begin
            zaddr[i] = (i * 16 + $urandom_range(0, 3) * 4) & 511;
            do_txn0(1'b1, zaddr[i], $urandom);
        end
        for (int i = 0; i < 8; i++) do_txn0(1'b0, zaddr[i], '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
